// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the decode hazard tracker: op-type
//               encodes and the forwarding-select width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Op-type encodes carried with each decoded / in-flight instruction
    typedef enum logic [1:0] {
        c_OP_IDLE  = 2'd0,
        c_OP_ALU   = 2'd1,
        c_OP_LOAD  = 2'd2,
        c_OP_STORE = 2'd3
    } op_type_t;

    // Forward select needs one code per tracked entry plus "regfile"
    function automatic int f_sel_width(input int n_stage);
        return $clog2(n_stage + 1);
    endfunction

endpackage : decode_pkg
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Priority match of one source register against the
//               in-flight scoreboard. Youngest writing entry wins and yields
//               the forward select, producer type and load-use hazard flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import decode_pkg::*;
#(
    parameter int NSTAGE           = 4,
    parameter int RA_W             = 5,
    parameter int TYPE_W           = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = 3
) (
    input  logic [NSTAGE-1:0]        i_valid,
    input  logic [NSTAGE*RA_W-1:0]   i_rd_flat,
    input  logic [NSTAGE*TYPE_W-1:0] i_type_flat,
    input  logic [RA_W-1:0]          i_src_sel,
    input  logic                     i_src_used,
    output logic [SEL_W-1:0]         o_mux_sel,
    output logic [TYPE_W-1:0]        o_src_type,
    output logic                     o_load_hazard
);

    localparam logic [TYPE_W-1:0] c_T_IDLE = TYPE_W'(c_OP_IDLE);
    localparam logic [TYPE_W-1:0] c_T_ALU  = TYPE_W'(c_OP_ALU);
    localparam logic [TYPE_W-1:0] c_T_LOAD = TYPE_W'(c_OP_LOAD);

    logic [TYPE_W-1:0] w_type;

    // Scan oldest to youngest so the youngest matching writer is left last
    always_comb begin
        o_mux_sel     = '0;
        o_src_type    = c_T_IDLE;
        o_load_hazard = 1'b0;
        w_type        = c_T_IDLE;
        if (i_src_used && (i_src_sel != '0)) begin
            for (int i = NSTAGE - 1; i >= 0; i--) begin
                w_type = i_type_flat[i*TYPE_W +: TYPE_W];
                if (i_valid[i] && ((w_type == c_T_ALU) || (w_type == c_T_LOAD)) &&
                    (i_rd_flat[i*RA_W +: RA_W] == i_src_sel)) begin
                    o_mux_sel     = SEL_W'(i + 1);
                    o_src_type    = w_type;
                    o_load_hazard = (w_type == c_T_LOAD) && (i < LOAD_READY_STAGE);
                end
            end
        end
    end

endmodule : hazard_match
`default_nettype wire

// File: rtl/decode_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : decode_hazard_unit
// Description : Decode-stage hazard / forwarding tracker. Shift-register
//               scoreboard of the NSTAGE downstream instructions, per-source
//               forward selects, load-use stall and issue handshake.
//               Optional stall counter enabled by DECODE_STALL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_hazard_unit
    import decode_pkg::*;
#(
    parameter int NSTAGE           = 4,
    parameter int RA_W             = 5,
    parameter int TYPE_W           = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int FLUSH_DEPTH      = 1,
    parameter int CNT_W            = 32,
    localparam int SEL_W           = f_sel_width(NSTAGE)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [RA_W-1:0]   RS1_SEL,
    input  logic [RA_W-1:0]   RS2_SEL,
    input  logic              RS1_USED,
    input  logic              RS2_USED,
    input  logic [RA_W-1:0]   RD_IN,
    input  logic [TYPE_W-1:0] TYPE_IN,
    input  logic              ADVANCE,
    input  logic              FLUSH,
    output logic [SEL_W-1:0]  MUX1_SEL,
    output logic [SEL_W-1:0]  MUX2_SEL,
    output logic [TYPE_W-1:0] RS1_TYPE,
    output logic [TYPE_W-1:0] RS2_TYPE,
    output logic              STALL,
    output logic              EX_VALID,
    output logic [CNT_W-1:0]  STALL_CNT
);

    localparam logic [TYPE_W-1:0] c_T_IDLE = TYPE_W'(c_OP_IDLE);

    logic [NSTAGE-1:0]        r_valid;
    logic [NSTAGE*RA_W-1:0]   r_rd_flat;
    logic [NSTAGE*TYPE_W-1:0] r_type_flat;
    logic                     w_haz1;
    logic                     w_haz2;

    hazard_match #(
        .NSTAGE           (NSTAGE),
        .RA_W             (RA_W),
        .TYPE_W           (TYPE_W),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_W            (SEL_W)
    ) u_match_rs1 (
        .i_valid       (r_valid),
        .i_rd_flat     (r_rd_flat),
        .i_type_flat   (r_type_flat),
        .i_src_sel     (RS1_SEL),
        .i_src_used    (RS1_USED),
        .o_mux_sel     (MUX1_SEL),
        .o_src_type    (RS1_TYPE),
        .o_load_hazard (w_haz1)
    );

    hazard_match #(
        .NSTAGE           (NSTAGE),
        .RA_W             (RA_W),
        .TYPE_W           (TYPE_W),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_W            (SEL_W)
    ) u_match_rs2 (
        .i_valid       (r_valid),
        .i_rd_flat     (r_rd_flat),
        .i_type_flat   (r_type_flat),
        .i_src_sel     (RS2_SEL),
        .i_src_used    (RS2_USED),
        .o_mux_sel     (MUX2_SEL),
        .o_src_type    (RS2_TYPE),
        .o_load_hazard (w_haz2)
    );

    assign STALL    = IN_VALID && (w_haz1 || w_haz2);
    assign IN_READY = IN_VALID && ADVANCE && !STALL && !FLUSH;
    assign EX_VALID = r_valid[0];

    // Scoreboard shift: moves only with the pipeline; flush kills the youngest entries
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid     <= '0;
            r_rd_flat   <= '0;
            r_type_flat <= '0;
        end else if (ADVANCE) begin
            for (int i = NSTAGE - 1; i >= 1; i--) begin
                r_valid[i]                      <= r_valid[i-1] && !(FLUSH && (i < FLUSH_DEPTH));
                r_rd_flat[i*RA_W +: RA_W]       <= r_rd_flat[(i-1)*RA_W +: RA_W];
                r_type_flat[i*TYPE_W +: TYPE_W] <= r_type_flat[(i-1)*TYPE_W +: TYPE_W];
            end
            // x0 destinations are stored invalid so they can never forward
            r_valid[0]              <= IN_READY && (RD_IN != '0);
            r_rd_flat[RA_W-1:0]     <= IN_READY ? RD_IN : '0;
            r_type_flat[TYPE_W-1:0] <= IN_READY ? TYPE_IN : c_T_IDLE;
        end
    end

`ifdef DECODE_STALL_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Count cycles lost to load-use stalls, saturating
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (STALL && ADVANCE && !FLUSH && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`else
    assign STALL_CNT = '0;
`endif

endmodule : decode_hazard_unit
`default_nettype wire
